regfile_mp: RTL and testbench

Parametrised multi-port register file for the MIPS core: successor of the two-read/one-write `regfile`. Provides `READ_PORTS` combinational read ports, two write ports (A and B, for two retiring pipeline stages), optional write-to-read bypass, hardwired-zero register 0, and a per-register busy scoreboard used by the hazard unit for stall decisions. Sits between decode (reads, reservations) and writeback (writes).

---
 rtl/regfile_mp_pkg.sv | 17 +
 rtl/regfile_rdport.sv | 59 +++++
 rtl/regfile_mp.sv | 107 ++++++++++
 tb/tb_regfile_mp.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default widths,
// the hardwired-zero register index, and the read-source selector type.
package regfile_mp_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int REG_ZERO   = 0;

   // Where a read port takes its data from in the current cycle.
   typedef enum logic [1:0] {
      SRC_ZERO  = 2'd0,
      SRC_STORE = 2'd1,
      SRC_BYP_A = 2'd2,
      SRC_BYP_B = 2'd3
   } rd_src_e;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: storage mux, optional same-cycle write
// bypass (port B has priority over port A) and busy-bit lookup.
module regfile_rdport
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int BYPASS = 1
) (
   input  logic                     rst,
   input  logic [ADDR_W-1:0]        num_i,
   input  logic [DATA_W-1:0]        regs_i [2**ADDR_W],
   input  logic [2**ADDR_W-1:0]     busy_q_i,
   input  logic [2**ADDR_W-1:0]     busy_d_i,
   input  logic                     wa_act_i,
   input  logic [ADDR_W-1:0]        wa_num_i,
   input  logic [DATA_W-1:0]        wa_data_i,
   input  logic                     wb_act_i,
   input  logic [ADDR_W-1:0]        wb_num_i,
   input  logic [DATA_W-1:0]        wb_data_i,
   output logic [DATA_W-1:0]        data_o,
   output logic                     busy_o
);

   rd_src_e src;

   // Pick the data source; reset and register 0 force zero.
   always_comb begin
      src = SRC_STORE;
      if (rst || (num_i == ADDR_W'(REG_ZERO))) begin
         src = SRC_ZERO;
      end else if ((BYPASS != 0) && wb_act_i && (wb_num_i == num_i)) begin
         src = SRC_BYP_B;
      end else if ((BYPASS != 0) && wa_act_i && (wa_num_i == num_i)) begin
         src = SRC_BYP_A;
      end
   end

   // Data mux driven by the selected source.
   always_comb begin
      data_o = '0;
      case (src)
         SRC_STORE: data_o = regs_i[num_i];
         SRC_BYP_A: data_o = wa_data_i;
         SRC_BYP_B: data_o = wb_data_i;
         default:   data_o = '0;
      endcase
   end

   // Busy lookup: with bypass the post-edge value is shown so a hazard unit
   // sees a same-cycle reserve or release immediately.
   always_comb begin
      busy_o = 1'b0;
      if (!rst) begin
         busy_o = (BYPASS != 0) ? busy_d_i[num_i] : busy_q_i[num_i];
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, optional write-to-read
// bypass, hardwired-zero register 0 and a per-register busy scoreboard.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int READ_PORTS = 2,
   parameter int BYPASS     = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [READ_PORTS*ADDR_W-1:0] read_num_i,
   output logic [READ_PORTS*DATA_W-1:0] read_data_o,
   output logic [READ_PORTS-1:0]        read_busy_o,
   input  logic                         wa_en_i,
   input  logic [ADDR_W-1:0]            wa_num_i,
   input  logic [DATA_W-1:0]            wa_data_i,
   input  logic                         wb_en_i,
   input  logic [ADDR_W-1:0]            wb_num_i,
   input  logic [DATA_W-1:0]            wb_data_i,
   input  logic                         rsv_en_i,
   input  logic [ADDR_W-1:0]            rsv_num_i,
   output logic [ADDR_W:0]              busy_count_o
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [ADDR_W:0]     busy_count_q;
   logic [ADDR_W:0]     busy_count_d;
   logic                wa_act;
   logic                wb_act;
   logic                rsv_act;

   // Accesses aimed at register 0 are dropped here so nothing downstream
   // ever has to special-case it.
   assign wa_act  = wa_en_i  && (wa_num_i  != ADDR_W'(REG_ZERO));
   assign wb_act  = wb_en_i  && (wb_num_i  != ADDR_W'(REG_ZERO));
   assign rsv_act = rsv_en_i && (rsv_num_i != ADDR_W'(REG_ZERO));

   // Next busy vector: writes release, then a reserve on the same register wins.
   always_comb begin
      busy_d = busy_q;
      if (wa_act) busy_d[wa_num_i] = 1'b0;
      if (wb_act) busy_d[wb_num_i] = 1'b0;
      if (rsv_act) busy_d[rsv_num_i] = 1'b1;
   end

   // Population count of the next busy vector so the count tracks busy_q exactly.
   always_comb begin
      busy_count_d = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[r]};
      end
   end

   // Busy scoreboard and its count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   // Register storage; port B is written last so it wins an index collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         if (wa_act) regs_q[wa_num_i] <= wa_data_i;
         if (wb_act) regs_q[wb_num_i] <= wb_data_i;
      end
   end

   assign busy_count_o = busy_count_q;

   for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
      regfile_rdport #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .BYPASS (BYPASS)
      ) u_rdport (
         .rst       (rst),
         .num_i     (read_num_i[p*ADDR_W +: ADDR_W]),
         .regs_i    (regs_q),
         .busy_q_i  (busy_q),
         .busy_d_i  (busy_d),
         .wa_act_i  (wa_act),
         .wa_num_i  (wa_num_i),
         .wa_data_i (wa_data_i),
         .wb_act_i  (wb_act),
         .wb_num_i  (wb_num_i),
         .wb_data_i (wb_data_i),
         .data_o    (read_data_o[p*DATA_W +: DATA_W]),
         .busy_o    (read_busy_o[p])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing and a non-bypassing 32x32 instance share
// one stimulus set; a 16-bit, 8-entry, 4-read-port instance has its own.
module tb_regfile_mp;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   // ---- shared stimulus for the two 32-bit instances
   logic [9:0]  read_num;
   logic        wa_en, wb_en, rsv_en;
   logic [4:0]  wa_num, wb_num, rsv_num;
   logic [31:0] wa_data, wb_data;

   logic [63:0] byp_data, nob_data;
   logic [1:0]  byp_busy, nob_busy;
   logic [5:0]  byp_cnt, nob_cnt;

   // ---- stimulus for the small instance
   logic [11:0] p_read_num;
   logic        p_wa_en, p_wb_en, p_rsv_en;
   logic [2:0]  p_wa_num, p_wb_num, p_rsv_num;
   logic [15:0] p_wa_data, p_wb_data;
   logic [63:0] p_data;
   logic [3:0]  p_busy;
   logic [3:0]  p_cnt;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .READ_PORTS(2), .BYPASS(1)) dut_byp (
      .clk(clk), .rst(rst), .read_num_i(read_num), .read_data_o(byp_data),
      .read_busy_o(byp_busy), .wa_en_i(wa_en), .wa_num_i(wa_num), .wa_data_i(wa_data),
      .wb_en_i(wb_en), .wb_num_i(wb_num), .wb_data_i(wb_data),
      .rsv_en_i(rsv_en), .rsv_num_i(rsv_num), .busy_count_o(byp_cnt));

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .READ_PORTS(2), .BYPASS(0)) dut_nob (
      .clk(clk), .rst(rst), .read_num_i(read_num), .read_data_o(nob_data),
      .read_busy_o(nob_busy), .wa_en_i(wa_en), .wa_num_i(wa_num), .wa_data_i(wa_data),
      .wb_en_i(wb_en), .wb_num_i(wb_num), .wb_data_i(wb_data),
      .rsv_en_i(rsv_en), .rsv_num_i(rsv_num), .busy_count_o(nob_cnt));

   regfile_mp #(.DATA_W(16), .ADDR_W(3), .READ_PORTS(4), .BYPASS(1)) dut_p (
      .clk(clk), .rst(rst), .read_num_i(p_read_num), .read_data_o(p_data),
      .read_busy_o(p_busy), .wa_en_i(p_wa_en), .wa_num_i(p_wa_num), .wa_data_i(p_wa_data),
      .wb_en_i(p_wb_en), .wb_num_i(p_wb_num), .wb_data_i(p_wb_data),
      .rsv_en_i(p_rsv_en), .rsv_num_i(p_rsv_num), .busy_count_o(p_cnt));

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      wa_en = 0; wa_num = 0; wa_data = 0;
      wb_en = 0; wb_num = 0; wb_data = 0;
      rsv_en = 0; rsv_num = 0;
   endtask

   task automatic p_idle();
      p_wa_en = 0; p_wa_num = 0; p_wa_data = 0;
      p_wb_en = 0; p_wb_num = 0; p_wb_data = 0;
      p_rsv_en = 0; p_rsv_num = 0;
   endtask

   typedef struct {
      logic        wa_en;  logic [4:0] wa_num;  logic [31:0] wa_data;
      logic        wb_en;  logic [4:0] wb_num;  logic [31:0] wb_data;
      logic        rsv_en; logic [4:0] rsv_num;
      logic [4:0]  rd0, rd1;
      logic [31:0] exp0, exp1;
      logic        eb0, eb1;
      logic [5:0]  ecnt;
   } vec_t;

   function automatic vec_t mk(
      input logic a_en, input logic [4:0] a_n, input logic [31:0] a_d,
      input logic b_en, input logic [4:0] b_n, input logic [31:0] b_d,
      input logic r_en, input logic [4:0] r_n,
      input logic [4:0] r0, input logic [4:0] r1,
      input logic [31:0] e0, input logic [31:0] e1,
      input logic b0, input logic b1, input logic [5:0] c);
      vec_t v;
      v.wa_en = a_en; v.wa_num = a_n; v.wa_data = a_d;
      v.wb_en = b_en; v.wb_num = b_n; v.wb_data = b_d;
      v.rsv_en = r_en; v.rsv_num = r_n;
      v.rd0 = r0; v.rd1 = r1; v.exp0 = e0; v.exp1 = e1;
      v.eb0 = b0; v.eb1 = b1; v.ecnt = c;
      return v;
   endfunction

   // Expected values are for the bypassing instance, sampled before the edge;
   // ecnt is the count registered at earlier edges.
   vec_t vt [18];

   initial begin
      logic [15:0] pe;
      //          A en/num/data          B en/num/data      rsv     rd0 rd1  exp0          exp1          b0 b1 cnt
      vt[0]  = mk(1, 3, 32'h12345678,   0, 0, 0,           0, 0,   3,  0,   32'h12345678, 32'h0,        0, 0, 0);
      vt[1]  = mk(0, 0, 0,              0, 0, 0,           0, 0,   3,  0,   32'h12345678, 32'h0,        0, 0, 0);
      vt[2]  = mk(1, 0, 32'hFFFFFFFF,   0, 0, 0,           0, 0,   0,  3,   32'h0,        32'h12345678, 0, 0, 0);
      vt[3]  = mk(0, 0, 0,              0, 0, 0,           0, 0,   0,  3,   32'h0,        32'h12345678, 0, 0, 0);
      vt[4]  = mk(1, 7, 32'h1111,       1, 7, 32'h2222,    0, 0,   7,  3,   32'h2222,     32'h12345678, 0, 0, 0);
      vt[5]  = mk(1, 8, 32'hAAAA,       1, 9, 32'hBBBB,    0, 0,   7,  8,   32'h2222,     32'hAAAA,     0, 0, 0);
      vt[6]  = mk(0, 0, 0,              0, 0, 0,           0, 0,   8,  9,   32'hAAAA,     32'hBBBB,     0, 0, 0);
      vt[7]  = mk(0, 0, 0,              0, 0, 0,           1, 10,  10, 11,  32'h0,        32'h0,        1, 0, 0);
      vt[8]  = mk(0, 0, 0,              0, 0, 0,           1, 11,  10, 11,  32'h0,        32'h0,        1, 1, 1);
      vt[9]  = mk(0, 0, 0,              0, 0, 0,           0, 0,   10, 11,  32'h0,        32'h0,        1, 1, 2);
      vt[10] = mk(1, 10, 32'h10,        0, 0, 0,           0, 0,   10, 11,  32'h10,       32'h0,        0, 1, 2);
      vt[11] = mk(0, 0, 0,              0, 0, 0,           0, 0,   10, 11,  32'h10,       32'h0,        0, 1, 1);
      vt[12] = mk(0, 0, 0,              1, 11, 32'h11,     1, 11,  11, 10,  32'h11,       32'h10,       1, 0, 1);
      vt[13] = mk(0, 0, 0,              0, 0, 0,           1, 0,   11, 0,   32'h11,       32'h0,        1, 0, 1);
      vt[14] = mk(0, 0, 0,              0, 0, 0,           0, 0,   0,  11,  32'h0,        32'h11,       0, 1, 1);
      vt[15] = mk(1, 4, 32'hCAFEF00D,   0, 0, 0,           0, 0,   4,  4,   32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 1);
      vt[16] = mk(1, 12, 32'h1,         1, 13, 32'h2,      1, 12,  12, 13,  32'h1,        32'h2,        1, 0, 1);
      vt[17] = mk(0, 0, 0,              0, 0, 0,           0, 0,   12, 13,  32'h1,        32'h2,        1, 0, 2);

      // ---- clock/reset
      idle(); p_idle();
      read_num = {5'd0, 5'd3};
      p_read_num = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_rd0", byp_data[31:0], 32'h0);
      check("reset_cnt", {26'h0, byp_cnt}, 32'h0);
      check("reset_busy", {30'h0, byp_busy}, 32'h0);
      rst = 1'b0;

      // ---- table-driven main sequence
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         wa_en = vt[i].wa_en; wa_num = vt[i].wa_num; wa_data = vt[i].wa_data;
         wb_en = vt[i].wb_en; wb_num = vt[i].wb_num; wb_data = vt[i].wb_data;
         rsv_en = vt[i].rsv_en; rsv_num = vt[i].rsv_num;
         read_num = {vt[i].rd1, vt[i].rd0};
         #1;
         check($sformatf("v%0d_rd0", i), byp_data[31:0], vt[i].exp0);
         check($sformatf("v%0d_rd1", i), byp_data[63:32], vt[i].exp1);
         check($sformatf("v%0d_busy0", i), {31'h0, byp_busy[0]}, {31'h0, vt[i].eb0});
         check($sformatf("v%0d_busy1", i), {31'h0, byp_busy[1]}, {31'h0, vt[i].eb1});
         check($sformatf("v%0d_cnt", i), {26'h0, byp_cnt}, {26'h0, vt[i].ecnt});
         check($sformatf("v%0d_nob_cnt", i), {26'h0, nob_cnt}, {26'h0, vt[i].ecnt});
      end

      // ---- bypass versus stored-state reads
      @(negedge clk);
      idle();
      wa_en = 1; wa_num = 4; wa_data = 32'h0BADF00D;
      rsv_en = 1; rsv_num = 14;
      read_num = {5'd14, 5'd4};
      #1;
      check("byp_same_cycle", byp_data[31:0], 32'h0BADF00D);
      check("nob_old_value", nob_data[31:0], 32'hCAFEF00D);
      check("byp_busy_rsv", {31'h0, byp_busy[1]}, 32'h1);
      check("nob_busy_rsv", {31'h0, nob_busy[1]}, 32'h0);
      @(negedge clk);
      idle();
      #1;
      check("nob_after_edge", nob_data[31:0], 32'h0BADF00D);
      check("nob_busy_after", {31'h0, nob_busy[1]}, 32'h1);
      check("nob_cnt_after", {26'h0, nob_cnt}, 32'h3);

      // ---- asynchronous reset mid-operation
      @(negedge clk);
      wa_en = 1; wa_num = 5; wa_data = 32'hDEADBEEF;
      rsv_en = 1; rsv_num = 5;
      read_num = {5'd3, 5'd5};
      @(negedge clk);
      idle();
      #1;
      check("pre_rst_r5", byp_data[31:0], 32'hDEADBEEF);
      check("pre_rst_cnt", {26'h0, byp_cnt}, 32'h4);
      @(negedge clk);
      wa_en = 1; wa_num = 5; wa_data = 32'h55;
      rsv_en = 1; rsv_num = 6;
      rst = 1'b1;
      #1;
      check("rst_imm_r5", byp_data[31:0], 32'h0);
      check("rst_imm_nob_r5", nob_data[31:0], 32'h0);
      check("rst_imm_cnt", {26'h0, byp_cnt}, 32'h0);
      check("rst_imm_busy", {30'h0, byp_busy}, 32'h0);
      @(negedge clk);
      check("rst_hold_cnt", {26'h0, byp_cnt}, 32'h0);
      check("rst_hold_nob_r5", nob_data[31:0], 32'h0);
      idle();
      rst = 1'b0;
      #1;
      check("post_rst_r5", nob_data[31:0], 32'h0);
      check("post_rst_r3", nob_data[63:32], 32'h0);
      @(negedge clk);
      wa_en = 1; wa_num = 6; wa_data = 32'h66;
      read_num = {5'd5, 5'd6};
      #1;
      check("post_rst_byp_r6", byp_data[31:0], 32'h66);
      @(negedge clk);
      idle();
      #1;
      check("post_rst_nob_r6", nob_data[31:0], 32'h66);
      check("post_rst_nob_r5", nob_data[63:32], 32'h0);
      check("post_rst_cnt", {26'h0, nob_cnt}, 32'h0);

      // ---- small parametrisation: fill r1..r7 and read back over 4 ports
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         p_idle();
         p_wa_en = 1; p_wa_num = 3'(i); p_wa_data = 16'(16'h0101 * i);
      end
      @(negedge clk);
      p_idle();
      p_read_num = {3'd4, 3'd3, 3'd2, 3'd1};
      #1;
      for (int k = 0; k < 4; k++) begin
         pe = 16'(16'h0101 * (k + 1));
         check($sformatf("p_lo_port%0d", k), {16'h0, p_data[k*16 +: 16]}, {16'h0, pe});
      end
      @(negedge clk);
      p_read_num = {3'd0, 3'd7, 3'd6, 3'd5};
      #1;
      for (int k = 0; k < 3; k++) begin
         pe = 16'(16'h0101 * (k + 5));
         check($sformatf("p_hi_port%0d", k), {16'h0, p_data[k*16 +: 16]}, {16'h0, pe});
      end
      check("p_r0_port3", {16'h0, p_data[63:48]}, 32'h0);

      // reserve every register, then try r0 as well
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         p_idle();
         p_rsv_en = 1; p_rsv_num = 3'(i);
      end
      @(negedge clk);
      p_idle();
      p_rsv_en = 1; p_rsv_num = 3'd0;
      #1;
      check("p_cnt_full", {28'h0, p_cnt}, 32'h7);
      @(negedge clk);
      p_idle();
      #1;
      check("p_cnt_rsv_r0", {28'h0, p_cnt}, 32'h7);
      check("p_busy_ports", {28'h0, p_busy}, 32'h7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
